alu32_result_stage: RTL and testbench

- Registered result stage directly downstream of the 32-bit ALU (modular or behavioral variant, identical port contract).
- Captures the combinational F/Cout with the issuing sel and operand sign bits, and derives Z/N/C/V status flags.
- Buffers results in a small FIFO with valid/ready handshakes on both sides.
- Keeps a saturating count of signed-overflow results for debug and performance readout.

---
 rtl/alu32_result_stage_pkg.sv | 27 ++
 rtl/alu32_result_stage_flag_gen.sv | 39 +++
 rtl/alu32_result_stage.sv | 105 ++++++++++
 tb/tb_alu32_result_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu32_result_stage_pkg.sv
// Shared definitions for the ALU result stage.
// Holds the sel field codes, the {Z,N,C,V} flag bit ordering and the FIFO entry layout.
package alu32_result_stage_pkg;

   // sel[3:2] group code for arithmetic operations
   localparam logic [1:0] OP_ARITH = 2'b00;

   // Arithmetic sub-codes on sel[1:0]
   localparam logic [1:0] AR_TRANSFER = 2'b00;
   localparam logic [1:0] AR_ADD      = 2'b01;
   localparam logic [1:0] AR_SUB      = 2'b10;
   localparam logic [1:0] AR_DEC      = 2'b11;

   // Flag vector bit positions, packed as {Z,N,C,V}
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [3:0] flags_t;

   typedef struct packed {
      logic [31:0] f;
      flags_t      flags;
   } entry_t;

endpackage

// File: rtl/alu32_result_stage_flag_gen.sv
// Combinational status-flag generator for one ALU result.
// Ports: i_sel, i_a_msb, i_b_msb, i_f, i_cout in; o_flags = {Z,N,C,V} out.
module alu32_result_stage_flag_gen
   import alu32_result_stage_pkg::*;
(
   input  logic [3:0]  i_sel,
   input  logic        i_a_msb,
   input  logic        i_b_msb,
   input  logic [31:0] i_f,
   input  logic        i_cout,
   output flags_t      o_flags
);

   logic w_beff;

   // Effective B sign seen by the adder for each arithmetic sub-code
   always_comb begin
      w_beff = 1'b0;
      unique case (i_sel[1:0])
         AR_TRANSFER: w_beff = 1'b0;
         AR_ADD:      w_beff = i_b_msb;
         AR_SUB:      w_beff = ~i_b_msb;
         AR_DEC:      w_beff = 1'b1;
         default:     w_beff = 1'b0;
      endcase
   end

   always_comb begin
      o_flags = '0;
      o_flags[FLAG_Z] = (i_f == 32'd0);
      o_flags[FLAG_N] = i_f[31];
      if (i_sel[3:2] == OP_ARITH) begin
         o_flags[FLAG_C] = i_cout;
         // Overflow: operands agree in sign, result sign differs
         o_flags[FLAG_V] = (i_a_msb == w_beff) && (i_f[31] != i_a_msb);
      end
   end

endmodule

// File: rtl/alu32_result_stage.sv
// Registered ALU result stage: flag capture, result FIFO, overflow counter.
// Ports: clk/rst_n; in_* push side; out_* pop side; ovf_count/ovf_clr debug.
module alu32_result_stage
   import alu32_result_stage_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_sel,
   input  logic             in_a_msb,
   input  logic             in_b_msb,
   input  logic [31:0]      in_f,
   input  logic             in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_f,
   output logic             out_z,
   output logic             out_n,
   output logic             out_c,
   output logic             out_v,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   entry_t           r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [CNT_W-1:0] r_cnt;

   flags_t w_flags;
   entry_t w_head;
   logic   w_full;
   logic   w_empty;
   logic   w_push;
   logic   w_pop;

   alu32_result_stage_flag_gen u_flag_gen (
      .i_sel   (in_sel),
      .i_a_msb (in_a_msb),
      .i_b_msb (in_b_msb),
      .i_f     (in_f),
      .i_cout  (in_cout),
      .o_flags (w_flags)
   );

   // Extra pointer MSB separates full (MSBs differ) from empty (equal)
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign w_push    = in_valid && !w_full;
   assign w_pop     = !w_empty && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      end
   end

   // Storage needs no reset: pointers alone decide what is visible
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= '{f: in_f, flags: w_flags};
      end
   end

   // Clear has priority over a same-cycle overflow increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (ovf_clr) begin
         r_cnt <= '0;
      end else if (w_push && w_flags[FLAG_V] && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   assign ovf_count = r_cnt;

   always_comb begin
      w_head = '0;
      if (!w_empty) w_head = r_mem[r_rptr[AW-1:0]];
   end

   assign out_f = w_head.f;
   assign out_z = w_head.flags[FLAG_Z];
   assign out_n = w_head.flags[FLAG_N];
   assign out_c = w_head.flags[FLAG_C];
   assign out_v = w_head.flags[FLAG_V];

endmodule

// File: tb/tb_alu32_result_stage.sv
// Directed self-checking bench for alu32_result_stage.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_alu32_result_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_sel;
   logic        in_a_msb;
   logic        in_b_msb;
   logic [31:0] in_f;
   logic        in_cout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_f;
   logic        out_z;
   logic        out_n;
   logic        out_c;
   logic        out_v;
   logic [15:0] ovf_count;
   logic        ovf_clr;

   int checks = 0;
   int errors = 0;

   // {out_valid, out_f, Z, N, C, V}
   logic [37:0] obs;
   assign obs = {out_valid, out_f, out_z, out_n, out_c, out_v};

   always #5 clk = ~clk;

   alu32_result_stage #(.DEPTH(2), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_a_msb  (in_a_msb),
      .in_b_msb  (in_b_msb),
      .in_f      (in_f),
      .in_cout   (in_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_f     (out_f),
      .out_z     (out_z),
      .out_n     (out_n),
      .out_c     (out_c),
      .out_v     (out_v),
      .ovf_count (ovf_count),
      .ovf_clr   (ovf_clr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] s, input logic a, input logic b,
                        input logic [31:0] f, input logic c);
      in_valid = 1'b1;
      in_sel   = s;
      in_a_msb = a;
      in_b_msb = b;
      in_f     = f;
      in_cout  = c;
   endtask

   task automatic push_one(input logic [3:0] s, input logic a, input logic b,
                           input logic [31:0] f, input logic c);
      drive(s, a, b, f, c);
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      in_sel = 4'd0; in_a_msb = 1'b0; in_b_msb = 1'b0;
      in_f = 32'd0; in_cout = 1'b0;
      #2;
      checks++;
      if (obs !== 38'd0 || ovf_count !== 16'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: obs=%h cnt=%h rdy=%b want 0/0/1", obs, ovf_count, in_ready);
      end
      step(); step();
      rst_n = 1'b1;
      step();
      checks++;
      if (obs !== 38'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: obs=%h rdy=%b want 0/1", obs, in_ready);
      end
   endtask

   task automatic test_add_carry();
      push_one(4'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
      checks++;
      if (obs !== {1'b1, 32'h7FFF_FFFF, 4'b0010}) begin
         errors++;
         $display("FAIL add_carry: got %h want %h", obs, {1'b1, 32'h7FFF_FFFF, 4'b0010});
      end
      checks++;
      if (ovf_count !== 16'd0) begin
         errors++;
         $display("FAIL add_carry_cnt: got %h want 0", ovf_count);
      end
      pop_one();
      checks++;
      if (obs !== 38'd0) begin
         errors++;
         $display("FAIL empty_zero: got %h want 0", obs);
      end
   endtask

   task automatic test_add_ovf();
      push_one(4'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      checks++;
      if (obs !== {1'b1, 32'h8000_0000, 4'b0101}) begin
         errors++;
         $display("FAIL add_ovf: got %h want %h", obs, {1'b1, 32'h8000_0000, 4'b0101});
      end
      checks++;
      if (ovf_count !== 16'd1) begin
         errors++;
         $display("FAIL add_ovf_cnt: got %h want 1", ovf_count);
      end
      pop_one();
   endtask

   task automatic test_dec_and_logic();
      push_one(4'd3, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
      checks++;
      if (obs !== {1'b1, 32'h7FFF_FFFF, 4'b0011}) begin
         errors++;
         $display("FAIL dec_ovf: got %h want %h", obs, {1'b1, 32'h7FFF_FFFF, 4'b0011});
      end
      pop_one();
      push_one(4'd6, 1'b1, 1'b1, 32'h0000_0000, 1'b1);
      checks++;
      if (obs !== {1'b1, 32'h0, 4'b1000}) begin
         errors++;
         $display("FAIL logic_zero: got %h want %h", obs, {1'b1, 32'h0, 4'b1000});
      end
      checks++;
      if (ovf_count !== 16'd2) begin
         errors++;
         $display("FAIL logic_cnt: got %h want 2", ovf_count);
      end
      pop_one();
      // SUB: beff = ~b_msb = 1, a_msb=1, F msb 0 -> overflow
      push_one(4'd2, 1'b1, 1'b0, 32'h0000_0001, 1'b1);
      checks++;
      if (obs !== {1'b1, 32'h1, 4'b0011} || ovf_count !== 16'd3) begin
         errors++;
         $display("FAIL sub_ovf: got %h cnt %h want %h cnt 3",
                  obs, ovf_count, {1'b1, 32'h1, 4'b0011});
      end
      pop_one();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(4'd6, 1'b0, 1'b0, 32'h1111_1111, 1'b0);
      step();
      checks++;
      if (in_ready !== 1'b1 || out_f !== 32'h1111_1111) begin
         errors++;
         $display("FAIL bp_first: rdy=%b f=%h want 1/11111111", in_ready, out_f);
      end
      drive(4'd6, 1'b0, 1'b0, 32'h2222_2222, 1'b0);
      step();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: rdy=%b want 0", in_ready);
      end
      drive(4'd6, 1'b0, 1'b0, 32'h3333_3333, 1'b0);
      step();
      checks++;
      if (in_ready !== 1'b0 || out_f !== 32'h1111_1111) begin
         errors++;
         $display("FAIL bp_hold: rdy=%b f=%h want 0/11111111", in_ready, out_f);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_f !== 32'h2222_2222) begin
         errors++;
         $display("FAIL bp_pop1: rdy=%b f=%h want 1/22222222", in_ready, out_f);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_f !== 32'h3333_3333 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_pop2: v=%b f=%h rdy=%b want 1/33333333/1",
                  out_valid, out_f, in_ready);
      end
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: v=%b want 0", out_valid);
      end
   endtask

   task automatic test_saturation();
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      checks++;
      if (ovf_count !== 16'd0) begin
         errors++;
         $display("FAIL clr: got %h want 0", ovf_count);
      end
      out_ready = 1'b1;
      drive(4'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      for (int i = 0; i < 16'hFFFE; i++) step();
      in_valid = 1'b0;
      checks++;
      if (ovf_count !== 16'hFFFE) begin
         errors++;
         $display("FAIL cnt_fffe: got %h want fffe", ovf_count);
      end
      for (int i = 0; i < 3; i++) begin
         push_one(4'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
         checks++;
         if (ovf_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_%0d: got %h want ffff", i, ovf_count);
         end
      end
      ovf_clr = 1'b1;
      push_one(4'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      ovf_clr = 1'b0;
      checks++;
      if (ovf_count !== 16'd0) begin
         errors++;
         $display("FAIL clr_wins: got %h want 0", ovf_count);
      end
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL sat_drain: v=%b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      push_one(4'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      push_one(4'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ovf_count !== 16'd2) begin
         errors++;
         $display("FAIL pre_rst: v=%b rdy=%b cnt=%h want 1/0/2",
                  out_valid, in_ready, ovf_count);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 38'd0 || ovf_count !== 16'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst: obs=%h cnt=%h rdy=%b want 0/0/1",
                  obs, ovf_count, in_ready);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (obs !== 38'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_rst: obs=%h rdy=%b want 0/1", obs, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_add_ovf();
      test_dec_and_logic();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
